// File: rtl/exe_pkg.sv
// Shared execute-stage definitions.
//   EXE_WIDTH       : datapath width of the EXE-stage adder
//   EXE_ADD_NREQ    : default number of requesters sharing the adder
//   exe_arb_state_t : output register occupancy of the adder arbiter
package exe_pkg;

    localparam int EXE_WIDTH    = 32;
    localparam int EXE_ADD_NREQ = 2;

    typedef enum logic {
        ARB_EMPTY,
        ARB_FULL
    } exe_arb_state_t;

endpackage

// File: rtl/EXE_ADDER.sv
// Shared EXE-stage adder: add_out = add_in1 + add_in2, modulo 2^WIDTH.
//   add_in1 : operand 1
//   add_in2 : operand 2
//   add_out : sum, carry-out discarded
module EXE_ADDER #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] add_in1,
    input  logic [WIDTH-1:0] add_in2,
    output logic [WIDTH-1:0] add_out
);

    assign add_out = add_in1 + add_in2;

endmodule

// File: rtl/exe_adder_arbiter.sv
// Round-robin arbiter sharing one EXE_ADDER among N_REQ requesters.
// The result is registered and tagged with the granted requester's index.
//   clk, rst_n : clock, synchronous active-low reset
//   req_valid  : per-requester operand valid
//   req_ready  : per-requester accept (combinational grant)
//   req_a/b    : packed operands, requester i at [i*WIDTH +: WIDTH]
//   rsp_valid  : registered result valid
//   rsp_ready  : consumer accepts result
//   rsp_sum    : registered sum
//   rsp_id     : index of the requester that produced rsp_sum
module exe_adder_arbiter
    import exe_pkg::*;
#(
    parameter int WIDTH = EXE_WIDTH,
    parameter int N_REQ = EXE_ADD_NREQ,
    parameter int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [WIDTH-1:0]       rsp_sum,
    output logic [ID_W-1:0]        rsp_id
);

    // Returns {found, index} of the first valid requester scanning upward from ptr.
    // Iterating from the far end lets the nearest hit overwrite earlier ones.
    function automatic logic [ID_W:0] rr_pick(input logic [N_REQ-1:0] valid,
                                              input logic [ID_W-1:0]  ptr);
        logic [ID_W:0] res;
        int            idx;
        res = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % N_REQ;
            if (valid[idx]) begin
                res = {1'b1, ID_W'(idx)};
            end
        end
        return res;
    endfunction

    exe_arb_state_t   state_q, state_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;

    logic [ID_W:0]    pick;
    logic             found;
    logic [ID_W-1:0]  grant_id;
    logic             can_accept;
    logic             grant;
    logic [ID_W-1:0]  sel_id;
    logic [WIDTH-1:0] add_a, add_b, add_out;

    always_comb begin
        pick     = rr_pick(req_valid, rr_ptr_q);
        found    = pick[ID_W];
        grant_id = pick[ID_W-1:0];
        // Reset gates acceptance so nothing is captured in a reset cycle.
        can_accept = rst_n && ((state_q == ARB_EMPTY) || rsp_ready);
        grant      = can_accept && found;
        for (int i = 0; i < N_REQ; i++) begin
            req_ready[i] = grant && (grant_id == ID_W'(i));
        end
    end

    // Operand mux: idle cycles present rr_ptr's operands; the sum is ignored then.
    always_comb begin
        sel_id = grant ? grant_id : rr_ptr_q;
        add_a  = '0;
        add_b  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (sel_id == ID_W'(i)) begin
                add_a = req_a[i*WIDTH +: WIDTH];
                add_b = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    EXE_ADDER #(
        .WIDTH (WIDTH)
    ) u_adder (
        .add_in1 (add_a),
        .add_in2 (add_b),
        .add_out (add_out)
    );

    always_comb begin
        state_d  = state_q;
        sum_d    = sum_q;
        id_d     = id_q;
        rr_ptr_d = rr_ptr_q;
        if (grant) begin
            state_d  = ARB_FULL;
            sum_d    = add_out;
            id_d     = grant_id;
            rr_ptr_d = (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + ID_W'(1);
        end else if ((state_q == ARB_FULL) && rsp_ready) begin
            // Drain only; sum/id keep their last values.
            state_d = ARB_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ARB_EMPTY;
            sum_q    <= '0;
            id_q     <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            sum_q    <= sum_d;
            id_q     <= id_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign rsp_valid = (state_q == ARB_FULL);
    assign rsp_sum   = sum_q;
    assign rsp_id    = id_q;

endmodule

// File: tb/tb_exe_adder_arbiter.sv
module tb_exe_adder_arbiter;

    localparam int W  = 32;
    localparam int N  = 3;
    localparam int IW = 2;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [W-1:0]   rsp_sum;
    logic [IW-1:0]  rsp_id;

    exe_adder_arbiter #(
        .WIDTH (W),
        .N_REQ (N),
        .ID_W  (IW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_id    (rsp_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One table row = one clock cycle: inputs, expected combinational ready,
    // expected registered response after the edge.
    typedef struct {
        logic         rst;
        logic [2:0]   valid;
        logic [95:0]  a;
        logic [95:0]  b;
        logic         rr;
        logic [2:0]   exp_ready;
        logic         exp_v;
        logic [31:0]  exp_sum;
        logic [1:0]   exp_id;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic [2:0] valid,
                                input logic [31:0] a0, input logic [31:0] b0,
                                input logic [31:0] a1, input logic [31:0] b1,
                                input logic rr, input logic [2:0] er,
                                input logic ev, input logic [31:0] es, input logic [1:0] ei);
        vec_t v;
        v.rst = rst; v.valid = valid;
        v.a = {32'd7, a1, a0};
        v.b = {32'd8, b1, b0};
        v.rr = rr; v.exp_ready = er; v.exp_v = ev; v.exp_sum = es; v.exp_id = ei;
        return v;
    endfunction

    // Behavioural reference: output slot, its contents and the round-robin start.
    logic        m_full;
    logic [31:0] m_sum;
    int          m_id;
    int          m_ptr;

    function automatic logic [2:0] model_ready(input logic r, input logic [2:0] v,
                                               input logic rr);
        if (!r || (m_full && !rr)) return 3'b000;
        for (int k = 0; k < N; k++) begin
            if (v[(m_ptr + k) % N]) return 3'(1 << ((m_ptr + k) % N));
        end
        return 3'b000;
    endfunction

    task automatic model_step(input logic r, input logic [2:0] rdy, input logic rr);
        logic [32:0] full_sum;
        if (!r) begin
            m_full = 0; m_sum = 0; m_id = 0; m_ptr = 0;
        end else if (rdy != 0) begin
            for (int i = 0; i < N; i++) begin
                if (rdy[i]) begin
                    full_sum = {1'b0, req_a[i*W +: W]} + {1'b0, req_b[i*W +: W]};
                    m_sum  = full_sum[31:0];
                    m_id   = i;
                    m_ptr  = (i + 1) % N;
                    m_full = 1;
                end
            end
        end else if (m_full && rr) begin
            m_full = 0;
        end
    endtask

    vec_t tbl[$];
    int   grants[N];

    initial begin
        rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset rsp_valid", 64'(rsp_valid), 0);
        chk("reset rsp_sum", 64'(rsp_sum), 0);

        //          rst valid a0            b0  a1  b1  rr ready  v  sum  id
        tbl.push_back(mk(0, 3'b111, 10,           20,  4,  2, 1, 3'b000, 0, 0,  0));
        tbl.push_back(mk(1, 3'b111, 10,           20,  4,  2, 1, 3'b001, 1, 30, 0));
        tbl.push_back(mk(1, 3'b011, 10,           20,  4,  2, 1, 3'b010, 1, 6,  1));
        tbl.push_back(mk(1, 3'b011, 10,           20,  4,  2, 1, 3'b001, 1, 30, 0));
        tbl.push_back(mk(1, 3'b011, 10,           20,  4,  2, 1, 3'b010, 1, 6,  1));
        tbl.push_back(mk(1, 3'b000, 10,           20,  4,  2, 1, 3'b000, 0, 6,  1));
        tbl.push_back(mk(1, 3'b010, 0,            0,  15, 25, 1, 3'b010, 1, 40, 1));
        tbl.push_back(mk(1, 3'b000, 0,            0,  15, 25, 1, 3'b000, 0, 40, 1));
        tbl.push_back(mk(1, 3'b001, 41,           26,  0,  0, 0, 3'b001, 1, 67, 0));
        tbl.push_back(mk(1, 3'b001, 41,           26,  0,  0, 0, 3'b000, 1, 67, 0));
        tbl.push_back(mk(1, 3'b001, 5,            5,   0,  0, 0, 3'b000, 1, 67, 0));
        tbl.push_back(mk(1, 3'b001, 32'hFFFF_FFFF, 2,  0,  0, 1, 3'b001, 1, 1,  0));
        tbl.push_back(mk(0, 3'b111, 3,            4,   5,  6, 0, 3'b000, 0, 0,  0));
        tbl.push_back(mk(1, 3'b000, 3,            4,   5,  6, 1, 3'b000, 0, 0,  0));

        foreach (tbl[r]) begin
            rst_n = tbl[r].rst; req_valid = tbl[r].valid; req_a = tbl[r].a;
            req_b = tbl[r].b; rsp_ready = tbl[r].rr;
            #1;
            chk($sformatf("row%0d req_ready", r), 64'(req_ready), 64'(tbl[r].exp_ready));
            @(posedge clk);
            #1;
            chk($sformatf("row%0d rsp_valid", r), 64'(rsp_valid), 64'(tbl[r].exp_v));
            chk($sformatf("row%0d rsp_sum", r), 64'(rsp_sum), 64'(tbl[r].exp_sum));
            chk($sformatf("row%0d rsp_id", r), 64'(rsp_id), 64'(tbl[r].exp_id));
        end

        // Fairness: all requesters valid, consumer always ready.
        foreach (grants[i]) grants[i] = 0;
        req_valid = 3'b111; rsp_ready = 1'b1;
        req_a = {32'd300, 32'd200, 32'd100}; req_b = {32'd3, 32'd2, 32'd1};
        for (int c = 0; c < 3 * N; c++) begin
            @(posedge clk);
            #1;
            chk("fair rsp_valid", 64'(rsp_valid), 1);
            chk("fair rsp_id", 64'(rsp_id), 64'(c % N));
            grants[rsp_id]++;
        end
        for (int i = 0; i < N; i++) chk($sformatf("fair count%0d", i), 64'(grants[i]), 3);

        // Resynchronise the model through a reset, then run random traffic.
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        m_full = 0; m_sum = 0; m_id = 0; m_ptr = 0;
        for (int c = 0; c < 400; c++) begin
            logic [2:0] er;
            rst_n     = ($urandom_range(0, 49) != 0);
            req_valid = 3'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                req_a[i*W +: W] = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
                req_b[i*W +: W] = $urandom;
            end
            er = model_ready(rst_n, req_valid, rsp_ready);
            #1;
            chk("rand req_ready", 64'(req_ready), 64'(er));
            model_step(rst_n, er, rsp_ready);
            @(posedge clk);
            #1;
            chk("rand rsp_valid", 64'(rsp_valid), 64'(m_full));
            chk("rand rsp_sum", 64'(rsp_sum), 64'(m_sum));
            chk("rand rsp_id", 64'(rsp_id), 64'(m_id));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/exe_adder_arbiter.md
# exe_adder_arbiter

Shares one EXE-stage 32-bit adder (`EXE_ADDER`, `add_in1 + add_in2 -> add_out`) among several requesters in the execute stage, such as the branch-target and effective-address calculations. Arbitration is round-robin with valid/ready handshakes on every requester port. Results come back through a single registered response port tagged with the requester index. The block sits between the EXE-stage control logic and the adder, and a stalled consumer back-pressures all requesters.

## Interface
- `WIDTH`, 32, operand and sum width
- `N_REQ`, 2, number of requesters (2..8)
- `ID_W`, `$clog2(N_REQ)` (min 1), width of requester index
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `req_valid`  in  N_REQ  per-requester operand valid
- `req_ready`  out  N_REQ  per-requester grant/accept
- `req_a`  in  N_REQ*WIDTH  operand A, requester i at bits [i*WIDTH +: WIDTH]
- `req_b`  in  N_REQ*WIDTH  operand B, same packing
- `rsp_valid`  out  1  registered result valid
- `rsp_ready`  in  1  consumer accepts result
- `rsp_sum`  out  WIDTH  registered sum
- `rsp_id`  out  ID_W  index of requester that produced `rsp_sum`

## Operation
- Output register states:
  - EMPTY (`rsp_valid`=0).
  - FULL (`rsp_valid`=1).
- `can_accept` = EMPTY, or (FULL and `rsp_ready`). Drain and refill happen in the same cycle.
- When `can_accept` is true, at most one requester is granted. The grant goes to the first asserted `req_valid` found scanning from `rr_ptr` upward, modulo N_REQ.
- `req_ready[i]` = `can_accept` and grant==i. It is combinational from `req_valid`, `rsp_ready` and state. Requesters must not make `req_valid` depend on `req_ready`.
- Handshake on port i (`req_valid[i]` and `req_ready[i]`) has these effects:
  - The adder is driven with `req_a[i]`/`req_b[i]`.
  - `rsp_sum` <= `add_out`, `rsp_id` <= i, state -> FULL.
  - `rr_ptr` <= (i+1) mod N_REQ.
- FULL with `rsp_ready`=1 and no grant: state -> EMPTY. `rsp_sum`/`rsp_id` hold their last values.
- FULL with `rsp_ready`=0: all `req_ready`=0 and the output is held stable, with no change to `rsp_sum`/`rsp_id`.
- Arithmetic is modulo 2^WIDTH. Carry-out is discarded and there is no overflow flag.
- When idle, the adder operand mux drives requester `rr_ptr`'s operands. The value is don't-care and is never captured.
- `rr_ptr` changes only on a grant. A lone requester is therefore served every cycle.

## Timing
- Reset (`rst_n`=0 at a rising edge):
  - `rsp_valid`=0, `rsp_sum`=0, `rsp_id`=0, `rr_ptr`=0, state EMPTY.
  - `req_ready` is forced to 0 combinationally while `rst_n`=0.
- Reset during FULL drops the pending result with no response. A handshake in the same cycle as reset is not accepted.
- Latency: request handshake at edge N -> `rsp_valid`=1 with the sum from edge N (visible in cycle N+1).
- Throughput: one result per cycle when `rsp_ready` is held at 1.
- Fairness: with all N_REQ requesters continuously valid, each is granted exactly once every N_REQ grants.
- `rsp_sum`/`rsp_id` are stable while `rsp_valid`=1 and `rsp_ready`=0.

## Structure
- Shared package `exe_pkg`:
  - `EXE_WIDTH` = 32.
  - `EXE_ADD_NREQ` default.
  - State enum `exe_arb_state_t` {ARB_EMPTY, ARB_FULL}.
- One sub-module: the existing `EXE_ADDER`, instantiated once and fed by the grant-selected operand mux.
- Round-robin grant logic stays inline as a function; it is not a separate module.

## Test plan
- Reset with all requesters valid and `rst_n`=0 -> `req_ready`=0 and `rsp_valid`=0. After release, the first grant goes to requester 0.
- Single request, requester 1 with A=15, B=25, `rsp_ready`=1 -> next cycle `rsp_valid`=1, `rsp_sum`=40, `rsp_id`=1, then `rsp_valid`=0.
- Both valid continuously, `rsp_ready`=1, req0 (10,20), req1 (4,2) -> alternating results 30/id0, 6/id1, 30/id0, ..., one per cycle.
- Back-pressure with `rsp_ready`=0 while FULL holding 67 (41+26) and req0 valid -> `req_ready`=0 and `rsp_sum` holds 67. When `rsp_ready` rises, req0 is granted the same cycle.
- Wrap-around: A=32'hFFFF_FFFF, B=2 -> `rsp_sum`=1 with carry discarded.
- Reset asserted while FULL -> next cycle `rsp_valid`=0, `rsp_sum`=0, and the pending result is never delivered.
